// File: rtl/arith_result_collector.sv
// Registered collector behind n_bit_arithmetic_compare: 2-entry in-order skid buffer
// plus running add/sub accumulator and saturating compare-event counters.

module arith_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear lands first so a same-cycle increment counts from zero.
  always_comb begin
    cnt_d = clear_i ? '0 : cnt_q;
    if (inc_i && cnt_d != {CNT_W{1'b1}}) cnt_d = cnt_d + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
endmodule

module arith_result_collector #(
  parameter int N     = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [N-1:0]     in_result,
  input  logic             in_equal,
  input  logic             in_less,
  input  logic             in_greater,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_op,
  output logic [N-1:0]     out_result,
  output logic [2:0]       out_flags,
  output logic [ACC_W-1:0] acc,
  output logic             acc_overflow,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] gt_count
);
  typedef struct packed {
    logic [1:0]   op;
    logic [N-1:0] result;
    logic [2:0]   flags;   // {greater, less, equal}
  } item_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} occ_e;

  occ_e  state_q;
  item_t head_q, skid_q, in_item;
  logic  push, pop;

  assign in_item.op     = in_op;
  assign in_item.result = in_result;
  assign in_item.flags  = {in_greater, in_less, in_equal};

  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // head_q always drives out_*; skid_q only holds the second item while in S_TWO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        S_EMPTY: if (push) begin
          head_q  <= in_item;
          state_q <= S_ONE;
        end
        S_ONE: begin
          if (push && pop) head_q <= in_item;
          else if (push) begin
            skid_q  <= in_item;
            state_q <= S_TWO;
          end else if (pop) state_q <= S_EMPTY;
        end
        S_TWO: if (pop) begin
          head_q  <= skid_q;
          state_q <= S_ONE;
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign out_op     = head_q.op;
  assign out_result = head_q.result;
  assign out_flags  = head_q.flags;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    acc_d = clear ? '0 : acc_q;
    ovf_d = clear ? 1'b0 : ovf_q;
    sum   = '0;
    if (push && !in_op[1]) begin
      sum   = {1'b0, acc_d} + {{(ACC_W+1-N){1'b0}}, in_result};
      acc_d = sum[ACC_W-1:0];
      ovf_d = ovf_d | sum[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc          = acc_q;
  assign acc_overflow = ovf_q;

  logic [2:0]            flag_inc;
  logic [2:0][CNT_W-1:0] cnt;

  assign flag_inc = {3{push && (in_op == 2'b10)}} & in_item.flags;

  for (genvar g = 0; g < 3; g++) begin : g_cnt
    arith_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (clear),
      .inc_i   (flag_inc[g]),
      .count_o (cnt[g])
    );
  end

  assign eq_count = cnt[0];
  assign lt_count = cnt[1];
  assign gt_count = cnt[2];
endmodule

// File: tb/tb_arith_result_collector.sv
// Bench for arith_result_collector: directed table, corner sequences, random vs queue model.

module tb_arith_result_collector;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_equal, in_less, in_greater, clear;
  logic [1:0] in_op, out_op;
  logic [7:0] in_result, out_result;
  logic       out_valid, out_ready;
  logic [2:0] out_flags;
  logic [15:0] acc;
  logic        acc_overflow;
  logic [7:0]  eq_count, lt_count, gt_count;

  always #5 clk = ~clk;

  arith_result_collector #(.N(8), .ACC_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_result(in_result),
    .in_equal(in_equal), .in_less(in_less), .in_greater(in_greater), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_result(out_result),
    .out_flags(out_flags), .acc(acc), .acc_overflow(acc_overflow),
    .eq_count(eq_count), .lt_count(lt_count), .gt_count(gt_count)
  );

  int n_cmp = 0, n_bad = 0;

  typedef struct {bit [1:0] op; bit [7:0] res; bit [2:0] fl;} mitem_t;
  mitem_t mq[$];
  int     macc, meq, mlt, mgt;
  bit     movf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit [1:0] op, input bit [7:0] res,
                       input bit [2:0] fl, input bit clr, input bit ordy);
    in_valid = v; in_op = op; in_result = res;
    {in_greater, in_less, in_equal} = fl;
    clear = clr; out_ready = ordy;
  endtask

  task automatic model_reset();
    mq.delete();
    macc = 0; movf = 0; meq = 0; mlt = 0; mgt = 0;
  endtask

  // Reference: a bounded FIFO of depth 2 plus integer statistics.
  task automatic model_step();
    bit a, c;
    mitem_t it;
    a = in_valid && (mq.size() < 2);
    c = (mq.size() > 0) && out_ready;
    it.op = in_op; it.res = in_result; it.fl = {in_greater, in_less, in_equal};
    if (c) void'(mq.pop_front());
    if (a) mq.push_back(it);
    if (clear) begin macc = 0; movf = 0; meq = 0; mlt = 0; mgt = 0; end
    if (a) begin
      if (it.op < 2) begin
        macc += it.res;
        if (macc >= 65536) begin macc -= 65536; movf = 1; end
      end else if (it.op == 2) begin
        if (it.fl[0] && meq < 255) meq++;
        if (it.fl[1] && mlt < 255) mlt++;
        if (it.fl[2] && mgt < 255) mgt++;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, out_valid, mq.size() > 0);
    chk({tag, ".in_ready"}, in_ready, mq.size() < 2);
    if (mq.size() > 0) begin
      chk({tag, ".out_op"}, out_op, mq[0].op);
      chk({tag, ".out_result"}, out_result, mq[0].res);
      chk({tag, ".out_flags"}, out_flags, mq[0].fl);
    end
    chk({tag, ".acc"}, acc, macc);
    chk({tag, ".acc_overflow"}, acc_overflow, movf);
    chk({tag, ".eq_count"}, eq_count, meq);
    chk({tag, ".lt_count"}, lt_count, mlt);
    chk({tag, ".gt_count"}, gt_count, mgt);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit vld; bit [1:0] op; bit [7:0] res; bit ordy;
    bit exp_ov; bit exp_ir; bit [7:0] exp_res; bit [15:0] exp_acc;
  } vec_t;
  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 2'b00, 8'h0B, 1, 1, 1, 8'h0B, 16'h000B};
    tbl[1]  = '{0, 2'b00, 8'h00, 0, 1, 1, 8'h0B, 16'h000B};
    tbl[2]  = '{1, 2'b01, 8'h11, 0, 1, 0, 8'h0B, 16'h001C};
    tbl[3]  = '{1, 2'b00, 8'h22, 0, 1, 0, 8'h0B, 16'h001C};
    tbl[4]  = '{1, 2'b00, 8'h22, 1, 1, 1, 8'h11, 16'h001C};
    tbl[5]  = '{1, 2'b00, 8'h22, 0, 1, 0, 8'h11, 16'h003E};
    tbl[6]  = '{0, 2'b00, 8'h00, 1, 1, 1, 8'h22, 16'h003E};
    tbl[7]  = '{0, 2'b00, 8'h00, 1, 0, 1, 8'h00, 16'h003E};
    tbl[8]  = '{1, 2'b11, 8'h55, 1, 1, 1, 8'h55, 16'h003E};
    tbl[9]  = '{1, 2'b00, 8'h01, 1, 1, 1, 8'h01, 16'h003F};
    tbl[10] = '{0, 2'b00, 8'h00, 1, 0, 1, 8'h00, 16'h003F};

    rst_n = 1'b0;
    drive(1, 0, 8'h77, 3'b111, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_result", out_result, 0);
    chk("rst.out_op", out_op, 0);
    chk("rst.out_flags", out_flags, 0);
    chk("rst.acc", acc, 0);
    chk("rst.acc_overflow", acc_overflow, 0);
    chk("rst.counts", {eq_count, lt_count, gt_count}, 0);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Directed: latency, backpressure into the skid, strict FIFO drain.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].vld, tbl[i].op, tbl[i].res, 3'b000, 0, tbl[i].ordy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d.out_valid", i), out_valid, tbl[i].exp_ov);
      chk($sformatf("tbl%0d.in_ready", i), in_ready, tbl[i].exp_ir);
      if (tbl[i].exp_ov) chk($sformatf("tbl%0d.out_result", i), out_result, tbl[i].exp_res);
      chk($sformatf("tbl%0d.acc", i), acc, tbl[i].exp_acc);
    end

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      drive(1, 2'b10, 8'($urandom), 3'b100, 0, 1);
      step();
      check_all("sat");
    end
    chk("sat.gt_final", gt_count, 255);
    chk("sat.eq_final", eq_count, 0);
    chk("sat.lt_final", lt_count, 0);

    // Accumulator wrap and sticky overflow.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1, 2'b00, 8'hFF, 0, 0, 1);
      step();
      check_all("pre");
    end
    drive(1, 2'b00, 8'hFA, 0, 0, 1); step();
    chk("ovf.acc_pre", acc, 16'hFFFA);
    chk("ovf.flag_pre", acc_overflow, 0);
    drive(1, 2'b00, 8'h07, 0, 0, 1); step();
    chk("ovf.acc_wrap", acc, 16'h0001);
    chk("ovf.flag_set", acc_overflow, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b01, 8'h05, 0, 0, 1); step();
      check_all("ovf_sticky");
    end
    chk("ovf.acc_after", acc, 16'h0010);
    chk("ovf.flag_sticky", acc_overflow, 1);

    // Clear with same-cycle compare-equal accept.
    drive(1, 2'b10, 8'h00, 3'b001, 1, 1); step();
    chk("clr.eq", eq_count, 1);
    chk("clr.acc", acc, 0);
    chk("clr.ovf", acc_overflow, 0);
    check_all("clr");

    // Async reset while full.
    drive(0, 0, 0, 0, 0, 1); step();
    drive(1, 2'b00, 8'h30, 0, 0, 0); step();
    drive(1, 2'b00, 8'h40, 0, 0, 0); step();
    chk("full.in_ready", in_ready, 0);
    check_all("full");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.out_valid", out_valid, 0);
    chk("arst.in_ready", in_ready, 1);
    check_all("arst");
    @(posedge clk); #1;
    check_all("arst_hold");
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1); step();
    check_all("arst_rel");

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(99) < 70, 2'($urandom), 8'($urandom), 3'($urandom),
            $urandom_range(99) < 3, $urandom_range(99) < 60);
      step();
      check_all("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
